bram_burst_writer: RTL and testbench
====================================

Name: bram_burst_writer

Overview:
- Write-side front end for the simple dual-port BRAM. Takes a burst command (base address, length) plus a valid/ready data stream with last marker, and produces the BRAM write-port signals ena/addra/dina.
- Checks stream framing against the commanded length, trims or drains mismatched bursts, and reports completion, beat count and length errors to the control logic.

Parameters:
- DATA_WIDTH, 32, width of stream data and BRAM word.
- ADDR_WIDTH, 10, BRAM address width; address space 2^ADDR_WIDTH words.

Ports:
- clka  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  burst command valid.
- cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready.
- cmd_addr  input  ADDR_WIDTH  base write address.
- cmd_len  input  ADDR_WIDTH  burst length minus 1 (0 => 1 beat, all-ones => 2^ADDR_WIDTH beats).
- s_valid  input  1  stream beat valid.
- s_ready  output  1  stream beat accepted when s_valid && s_ready.
- s_data  input  DATA_WIDTH  stream beat data.
- s_last  input  1  final beat of packet.
- ena  output  1  BRAM write enable.
- addra  output  ADDR_WIDTH  BRAM write address.
- dina  output  DATA_WIDTH  BRAM write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- err_short  output  1  with done: s_last arrived before cmd_len+1 beats.
- err_long  output  1  with done: cmd_len+1 beats written without s_last; excess beats discarded.
- wr_count  output  ADDR_WIDTH+1  beats actually written in the last completed burst; holds until next done.

Behaviour:
- Reset is synchronous, active-low (rst_n), on clka. While rst_n low at a rising edge, the following are cleared:
  - state to IDLE;
  - ena, addra, dina, done, err_short, err_long, busy, wr_count to 0.
- cmd_ready = 1 and s_ready = 0 in the first cycle after reset release.
- States: IDLE, WRITE, DRAIN.
- cmd_ready = (state==IDLE); s_ready = (state==WRITE || state==DRAIN); purely combinational from state, no dependence on s_valid.
- IDLE -> WRITE on command handshake:
  - latch the address pointer = cmd_addr;
  - latch remaining = cmd_len (ADDR_WIDTH bits);
  - clear the beat counter.
- WRITE, per stream handshake at edge T, registered outputs at T+1:
  - ena=1, addra=pointer, dina=s_data;
  - pointer increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0);
  - beat counter increments.
- ena=0 in every cycle without a WRITE-state handshake on the previous edge. Stalls (s_valid=0) insert no writes and no state change.
- WRITE exit conditions, evaluated on each handshake in WRITE:
  - remaining==0 and s_last=1: normal end -> IDLE; done=1 at T+1.
  - remaining!=0 and s_last=1: short -> IDLE; done=1, err_short=1 at T+1.
  - remaining==0 and s_last=0: long -> DRAIN; the beat is still written; no done yet.
  - Otherwise remaining decrements.
- DRAIN:
  - s_ready=1; beats accepted and discarded, ena stays 0.
  - On handshake with s_last=1 -> IDLE; done=1, err_long=1 next cycle.
- done/err pulses last exactly one cycle.
- wr_count updates in the same cycle as done:
  - normal = cmd_len+1;
  - short = beats received;
  - long = cmd_len+1.
- Last-beat timing: the final ena coincides with done for normal and short ends. cmd_ready is high in that same cycle, so a new command may be accepted there. Back-to-back bursts therefore have a one-cycle gap on s_ready.
- Full-space burst: cmd_len = 2^ADDR_WIDTH-1 writes every address exactly once and wraps the pointer back to cmd_addr; wr_count = 2^ADDR_WIDTH (needs the extra bit).
- Stream beats presented in IDLE are not accepted (s_ready=0) and are held by the source.
- Reset mid-burst aborts immediately: no further ena, no done pulse, partial data in BRAM is left as is.
- Latency, handshake to BRAM write enable: 1 cycle. Data is resident in BRAM after the following clka edge.

Test Plan:
- Normal burst: cmd_addr=0x010, cmd_len=3, 4 beats 0xA0..0xA3 with s_last on beat 4, no stalls -> ena for 4 consecutive cycles at addra 0x010..0x013 with matching dina; done=1 with the 4th ena; wr_count=4; no err.
- Wrap plus stalls: cmd_addr=0x3FE, cmd_len=3, s_valid toggled 1,0,1,1,0,1 -> addra 0x3FE,0x3FF,0x000,0x001; ena only after accepted beats; done=1, wr_count=4.
- Short packet: cmd_len=7, s_last on 3rd beat -> 3 writes; done=err_short=1 same cycle; wr_count=3; cmd_ready=1 that cycle.
- Long packet: cmd_len=1, 5 beats with s_last on 5th -> 2 writes only; beats 3-5 accepted with ena=0; done=err_long=1 one cycle after 5th handshake; wr_count=2.
- Single beat and back-to-back: cmd_len=0 at 0x100, then next command accepted the cycle done fires -> one write at 0x100; second burst starts with s_ready low for exactly one cycle between bursts.
- Reset mid-burst: rst_n low for 1 edge after 2 of 8 beats -> ena=0, busy=0, done never pulses, cmd_ready=1 next cycle; wr_count=0.

Source files
------------

// File: rtl/bram_burst_writer.sv
// bram_burst_writer: write-side front end for a simple dual-port BRAM.
// Accepts a burst command (base address, length-1) and a data stream with
// a last marker. Turns accepted beats into registered ena/addra/dina writes.
// Checks the stream framing against the commanded length and reports the
// outcome with a one-cycle done pulse plus error flags and a beat count.
//
// Handshake semantics: a transfer happens on a rising clka edge when both
// valid and ready are high. Ready never depends on valid. Once the source
// raises valid, it holds valid and its payload stable until the transfer.
// cmd_ready is high only in IDLE. s_ready is high only in WRITE and DRAIN.
module bram_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  ena,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_long,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;        // next BRAM address to write
  logic [ADDR_WIDTH-1:0] remaining;  // beats left after the current one
  logic [ADDR_WIDTH:0]   beat_cnt;   // beats written so far in this burst

  logic cmd_hs;
  logic wr_hs;
  logic drain_hs;
  logic at_final;

  // Ready signals and busy come from state alone.
  assign cmd_ready = (state == IDLE);
  assign s_ready   = (state == WRITE) || (state == DRAIN);
  assign busy      = (state != IDLE);

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign wr_hs    = (state == WRITE) && s_valid;
  assign drain_hs = (state == DRAIN) && s_valid;
  // The current beat is the last one the command allows.
  assign at_final = (remaining == '0);

  // Burst sequencing: command latch, length tracking, overrun drain.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
            beat_cnt  <= '0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            // The pointer wraps naturally at 2^ADDR_WIDTH.
            ptr      <= ptr + ADDR_ONE;
            beat_cnt <= beat_cnt + CNT_ONE;
            if (s_last) begin
              state <= IDLE;
            end else if (at_final) begin
              // Too many beats: swallow the rest of the packet.
              state <= DRAIN;
            end else begin
              remaining <= remaining - ADDR_ONE;
            end
          end
        end
        DRAIN: begin
          if (drain_hs && s_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // BRAM write port: one registered write per beat accepted in WRITE.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      ena   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena <= wr_hs;
      if (wr_hs) begin
        addra <= ptr;
        dina  <= s_data;
      end
    end
  end

  // Completion status: one-cycle pulses; wr_count holds between bursts.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      done      <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      wr_count  <= '0;
    end else begin
      done      <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      if (wr_hs && s_last) begin
        // Normal or short end. The count includes the beat being written now.
        done      <= 1'b1;
        err_short <= !at_final;
        wr_count  <= beat_cnt + CNT_ONE;
      end else if (drain_hs && s_last) begin
        // Long end. beat_cnt already holds cmd_len+1 written beats.
        done     <= 1'b1;
        err_long <= 1'b1;
        wr_count <= beat_cnt;
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_writer.sv
// Directed testbench for bram_burst_writer.
// Inputs change 1ns after each rising edge. Outputs are sampled at that
// same point, before the inputs for the next edge are driven.
module tb_bram_burst_writer;

  logic        clka;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        ena;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic        busy;
  logic        done;
  logic        err_short;
  logic        err_long;
  logic [10:0] wr_count;

  int checks;
  int failures;

  bram_burst_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clka(clka), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .ena(ena), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .err_short(err_short), .err_long(err_long),
    .wr_count(wr_count)
  );

  // Clock and reset.
  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Driver: present one command and wait a bounded time for acceptance.
  task automatic send_cmd(input logic [9:0] a, input logic [9:0] l);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_wait: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) step();
    checks++;
    if ({ena, addra, dina, done, err_short, err_long, busy, wr_count} !== 60'd0) begin
      failures++;
      $display("FAIL reset_outputs: ena=%b addra=%h dina=%h done=%b es=%b el=%b busy=%b wr_count=%0d required all 0",
               ena, addra, dina, done, err_short, err_long, busy, wr_count);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({cmd_ready, s_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release_ready: cmd_ready=%b s_ready=%b required 1 0", cmd_ready, s_ready);
    end
  endtask

  task automatic test_idle_stream();
    s_valid = 1'b1; s_data = 32'hDEAD; s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({s_ready, ena, done} !== 3'b000) begin
        failures++;
        $display("FAIL idle_stream cyc=%0d: s_ready=%b ena=%b done=%b required 0 0 0", i, s_ready, ena, done);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_normal();
    logic [9:0]  ea;
    logic [31:0] ed;
    send_cmd(10'h010, 10'd3);
    for (int i = 0; i < 4; i++) begin
      ea = 10'h010 + i[9:0];
      ed = 32'hA0 + i;
      s_valid = 1'b1; s_data = ed; s_last = (i == 3);
      step();
      checks++;
      if ({ena, addra, dina} !== {1'b1, ea, ed}) begin
        failures++;
        $display("FAIL normal_write beat=%0d: ena=%b addra=%h dina=%h required 1 %h %h", i, ena, addra, dina, ea, ed);
      end
      checks++;
      if ({done, err_short, err_long} !== {(i == 3), 2'b00}) begin
        failures++;
        $display("FAIL normal_status beat=%0d: done=%b es=%b el=%b required %b 0 0", i, done, err_short, err_long, (i == 3));
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if ({wr_count, cmd_ready} !== {11'd4, 1'b1}) begin
      failures++;
      $display("FAIL normal_count: wr_count=%0d cmd_ready=%b required 4 1", wr_count, cmd_ready);
    end
    step();
    checks++;
    if ({ena, done, busy, wr_count} !== {3'b000, 11'd4}) begin
      failures++;
      $display("FAIL normal_after: ena=%b done=%b busy=%b wr_count=%0d required 0 0 0 4", ena, done, busy, wr_count);
    end
  endtask

  task automatic test_wrap_stalls();
    int pat[6];
    int k;
    logic [9:0] ea;
    pat = '{1, 0, 1, 1, 0, 1};
    k = 0;
    send_cmd(10'h3FE, 10'd3);
    for (int j = 0; j < 6; j++) begin
      s_valid = (pat[j] == 1);
      s_data  = 32'hB0 + k;
      s_last  = (pat[j] == 1) && (k == 3);
      step();
      if (pat[j] == 1) begin
        ea = 10'h3FE + k[9:0];
        checks++;
        if ({ena, addra, dina, done} !== {1'b1, ea, 32'hB0 + k, (k == 3)}) begin
          failures++;
          $display("FAIL wrap_write beat=%0d: ena=%b addra=%h dina=%h done=%b required 1 %h %h %b",
                   k, ena, addra, dina, done, ea, 32'hB0 + k, (k == 3));
        end
        k++;
      end else begin
        checks++;
        if ({ena, done, busy} !== 3'b001) begin
          failures++;
          $display("FAIL wrap_stall cyc=%0d: ena=%b done=%b busy=%b required 0 0 1", j, ena, done, busy);
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if ({wr_count, err_short, err_long} !== {11'd4, 2'b00}) begin
      failures++;
      $display("FAIL wrap_count: wr_count=%0d es=%b el=%b required 4 0 0", wr_count, err_short, err_long);
    end
    step();
  endtask

  task automatic test_short();
    send_cmd(10'h020, 10'd7);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'hC0 + i; s_last = (i == 2);
      step();
      checks++;
      if ({ena, addra, done, err_short} !== {1'b1, 10'h020 + i[9:0], (i == 2), (i == 2)}) begin
        failures++;
        $display("FAIL short_beat=%0d: ena=%b addra=%h done=%b es=%b required 1 %h %b %b",
                 i, ena, addra, done, err_short, 10'h020 + i[9:0], (i == 2), (i == 2));
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if ({wr_count, cmd_ready, err_long} !== {11'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL short_end: wr_count=%0d cmd_ready=%b el=%b required 3 1 0", wr_count, cmd_ready, err_long);
    end
    step();
    checks++;
    if ({done, err_short, ena} !== 3'b000) begin
      failures++;
      $display("FAIL short_pulse: done=%b es=%b ena=%b required 0 0 0", done, err_short, ena);
    end
  endtask

  task automatic test_long();
    send_cmd(10'h040, 10'd1);
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        checks++;
        if ({s_ready, busy, cmd_ready} !== 3'b110) begin
          failures++;
          $display("FAIL long_drain_ready beat=%0d: s_ready=%b busy=%b cmd_ready=%b required 1 1 0", i, s_ready, busy, cmd_ready);
        end
      end
      s_valid = 1'b1; s_data = 32'hD0 + i; s_last = (i == 4);
      step();
      checks++;
      if (i < 2) begin
        if ({ena, addra, dina, done} !== {1'b1, 10'h040 + i[9:0], 32'hD0 + i, 1'b0}) begin
          failures++;
          $display("FAIL long_write beat=%0d: ena=%b addra=%h dina=%h done=%b required 1 %h %h 0",
                   i, ena, addra, dina, done, 10'h040 + i[9:0], 32'hD0 + i);
        end
      end else begin
        if ({ena, done, err_long} !== {1'b0, (i == 4), (i == 4)}) begin
          failures++;
          $display("FAIL long_discard beat=%0d: ena=%b done=%b el=%b required 0 %b %b", i, ena, done, err_long, (i == 4), (i == 4));
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if ({wr_count, err_short, cmd_ready} !== {11'd2, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL long_end: wr_count=%0d es=%b cmd_ready=%b required 2 0 1", wr_count, err_short, cmd_ready);
    end
    step();
  endtask

  task automatic test_back_to_back();
    send_cmd(10'h100, 10'd0);
    s_valid = 1'b1; s_data = 32'h0D0; s_last = 1'b1;
    step();
    checks++;
    if ({ena, addra, dina, done, wr_count, cmd_ready, s_ready} !== {1'b1, 10'h100, 32'h0D0, 1'b1, 11'd1, 2'b10}) begin
      failures++;
      $display("FAIL b2b_single: ena=%b addra=%h dina=%h done=%b wr_count=%0d cmd_ready=%b s_ready=%b required 1 100 d0 1 1 1 0",
               ena, addra, dina, done, wr_count, cmd_ready, s_ready);
    end
    // New command in the done cycle, first beat already presented.
    cmd_valid = 1'b1; cmd_addr = 10'h200; cmd_len = 10'd1;
    s_valid = 1'b1; s_data = 32'hE0; s_last = 1'b0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({ena, s_ready, busy} !== 3'b011) begin
      failures++;
      $display("FAIL b2b_gap: ena=%b s_ready=%b busy=%b required 0 1 1", ena, s_ready, busy);
    end
    step();
    checks++;
    if ({ena, addra, dina, done} !== {1'b1, 10'h200, 32'hE0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_beat0: ena=%b addra=%h dina=%h done=%b required 1 200 e0 0", ena, addra, dina, done);
    end
    s_data = 32'hE1; s_last = 1'b1;
    step();
    checks++;
    if ({ena, addra, dina, done, wr_count} !== {1'b1, 10'h201, 32'hE1, 1'b1, 11'd2}) begin
      failures++;
      $display("FAIL b2b_beat1: ena=%b addra=%h dina=%h done=%b wr_count=%0d required 1 201 e1 1 2",
               ena, addra, dina, done, wr_count);
    end
    s_valid = 1'b0; s_last = 1'b0;
    step();
  endtask

  task automatic test_full_space();
    int bad;
    int seen[1024];
    int not_once;
    logic [9:0] ea;
    bad = 0;
    not_once = 0;
    for (int i = 0; i < 1024; i++) seen[i] = 0;
    send_cmd(10'h155, 10'h3FF);
    for (int i = 0; i < 1024; i++) begin
      s_valid = 1'b1; s_data = i; s_last = (i == 1023);
      step();
      ea = 10'h155 + i[9:0];
      if (ena === 1'b1) seen[addra]++;
      if ({ena, addra, dina, done} !== {1'b1, ea, i[31:0], (i == 1023)}) begin
        bad++;
        if (bad <= 4)
          $display("  full_space beat=%0d ena=%b addra=%h dina=%h done=%b expected addra=%h", i, ena, addra, dina, done, ea);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_space_writes: %0d bad beats required 0", bad);
    end
    for (int i = 0; i < 1024; i++) if (seen[i] != 1) not_once++;
    checks++;
    if (not_once != 0) begin
      failures++;
      $display("FAIL full_space_coverage: %0d addresses not written exactly once required 0", not_once);
    end
    checks++;
    if ({wr_count, err_short, err_long} !== {11'd1024, 2'b00}) begin
      failures++;
      $display("FAIL full_space_count: wr_count=%0d es=%b el=%b required 1024 0 0", wr_count, err_short, err_long);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    int ena_seen;
    done_seen = 0;
    ena_seen = 0;
    send_cmd(10'h300, 10'd7);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hF0 + i; s_last = 1'b0;
      step();
    end
    s_data = 32'hF2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s_valid = 1'b0;
    checks++;
    if ({ena, busy, done, err_short, err_long, wr_count} !== 16'd0) begin
      failures++;
      $display("FAIL midreset_outputs: ena=%b busy=%b done=%b es=%b el=%b wr_count=%0d required all 0",
               ena, busy, done, err_short, err_long, wr_count);
    end
    checks++;
    if ({cmd_ready, s_ready} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_ready: cmd_ready=%b s_ready=%b required 1 0", cmd_ready, s_ready);
    end
    s_valid = 1'b1; s_data = 32'hF3; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done === 1'b1) done_seen++;
      if (ena === 1'b1) ena_seen++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (done_seen != 0 || ena_seen != 0) begin
      failures++;
      $display("FAIL midreset_quiet: done pulses=%0d ena cycles=%0d required 0 0", done_seen, ena_seen);
    end
  endtask

  // Hard bound on the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle_stream();
    test_normal();
    test_wrap_stalls();
    test_short();
    test_long();
    test_back_to_back();
    test_full_space();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
